red_pitaya_pwm_dither: RTL
==========================

# red_pitaya_pwm_dither

Dithered PWM generator that consumes the 24-bit PWM configuration words produced by the analog mixed-signal register block (`dac_a_o`..`dac_d_o`) and drives one PWM output pin. The block produces an 8-bit duty cycle over a 256-cycle base period. A 16-bit per-period dither pattern extends the duty by one clock in selected periods, giving 12-bit effective resolution over a 16-period dither cycle. Four instances sit between the register block and the analog PWM output pins, in the 250 MHz PWM clock domain.

## Interface
- `CCW`, 24: configuration word width. Bits [23:16] are the duty; bits [15:0] are the dither pattern.
- `clk_i` input, 1 bit: PWM clock, 250 MHz.
- `rstn_i` input, 1 bit: reset. One clock; reset is asynchronous and active-low.
- `cfg_i` input, CCW bits: configuration word. Sampled only at the period boundary.
- `pwm_o` output, 1 bit: PWM output, registered.
- `period_o` output, 1 bit: one-cycle pulse, coincident with the shadow-register load.
- `seq_o` output, 1 bit: one-cycle pulse when the dither index wraps from 15 to 0.

## Operation
- **State.**
  - 8-bit period counter `cnt`.
  - 4-bit dither index `idx`.
  - Shadow registers `duty_r[7:0]` and `pat_r[15:0]`.
- **Counter.** `cnt` increments every cycle and wraps from 255 to 0. There is no idle state and no enable.
- **Boundary, on the edge where `cnt`==255:**
  - `cnt` becomes 0.
  - `idx` becomes `idx`+1 (mod 16).
  - `duty_r` loads `cfg_i[23:16]` and `pat_r` loads `cfg_i[15:0]`.
  - `cfg_i` changes at any other time have no effect until the next boundary. There is no glitch and no partial-period update.
- **Dither bit.** `d` = `pat_r[idx]`. Index 0 uses the LSB. With the encoder's pattern layout, each set fractional bit spreads evenly across the 16 periods.
- **Compare.** Every cycle, `pwm_o` <= ({1'b0,`cnt`} < ({1'b0,`duty_r`} + `d`)).
  - The compare is 9 bits wide, so `duty_r`=255 with `d`=1 gives 256 and the output is high for all 256 cycles.
  - `duty_r`=0 with `d`=0 gives an output that is always low.
- **High time.** Per period, high time = `duty_r` + `d` cycles, range 0..256. Over 16 periods, total high time = 16·`duty_r` + popcount(`pat_r`) cycles, provided `cfg_i` is constant.
- **`period_o`.** Registered; high for the one cycle after the boundary edge, i.e. while `cnt`==0.
- **`seq_o`.** Registered; high while `cnt`==0 and `idx`==0, only after a wrap from 15 (not directly after reset).
- **Reset.** Asynchronous assertion of `rstn_i` forces the following values immediately, independent of the clock:
  - `cnt`=0, `idx`=0.
  - `duty_r`=0, `pat_r`=0.
  - `pwm_o`=0, `period_o`=0, `seq_o`=0.
- **Reset release.** The first period after release uses `duty_r`=0, so its output is low. `cfg_i` is first loaded at the end of that period.
- **Reset mid-period.** The current period is abandoned; there is no completion or flush.

## Timing
- Output latency is 1 cycle: `pwm_o` in cycle t+1 reflects `cnt` and the shadow registers in cycle t.
- Rising edges in a period with duty > 0 fall at `cnt`==0 plus 1 cycle. The output stays high for exactly `duty_r`+`d` consecutive cycles.
- `cfg_i` to output: a value present on the boundary edge governs the output of the whole following period. Worst case is 256 + 1 cycles.
- Base period: 256 cycles (976.5625 kHz at 250 MHz). Dither cycle: 4096 cycles.
- Critical path: 9-bit add plus 9-bit compare. This closes at 250 MHz with no extra pipelining.

## Structure
- A shared package `pwm_pkg` holds:
  - `CCW`.
  - Field positions `DUTY_MSB`=23, `DUTY_LSB`=16, `PAT_MSB`=15.
  - `PERIOD`=256.
  - `NSEQ`=16.
  
  The register block uses the same constants to pack the word.
- No sub-module. The block is a single flat module; the four PWM channels are separate instances at the top level.

## Test plan
- **50% duty, no dither.** `cfg_i`=24'h80_0000 held → each period shows exactly 128 high cycles starting at `cnt`=0 (+1 latency); `period_o` pulses every 256 cycles.
- **Full scale.** `cfg_i`=24'hFF_FFFF → `pwm_o` constantly 1 from the second period on. `cfg_i`=24'h00_0000 → `pwm_o` constantly 0.
- **Single dither bit.** `cfg_i`=24'h40_0001 → the period with `idx`=0 has 65 high cycles and the other 15 periods have 64. Total over 16 periods is 1025; `seq_o` pulses every 4096 cycles.
- **Mid-period update.** Change `cfg_i` from 24'h20_0000 to 24'hC0_0000 at `cnt`=100 → the current period stays at 32 high cycles; the next period has 192.
- **Async reset mid-operation.** Assert `rstn_i` at `cnt`=50 while `pwm_o`=1 → `pwm_o`=0 with no clock edge required. After release, the first period is fully low and the second uses `cfg_i`.
- **Long-run accumulation.** Random `cfg_i` held for 4096 cycles → the scoreboard high-count equals 16·duty + popcount(pattern).

Source files
------------

// File: rtl/pwm_pkg.sv
// Constants shared by the PWM dither generator and the register block that
// packs its configuration words.
package pwm_pkg;

  // Configuration word: duty in the top byte, dither pattern below it
  localparam int CCW      = 24;
  localparam int DUTY_MSB = 23;
  localparam int DUTY_LSB = 16;
  localparam int PAT_MSB  = 15;

  // Base PWM period in clocks and number of periods in one dither cycle
  localparam int PERIOD   = 256;
  localparam int NSEQ     = 16;

endpackage : pwm_pkg

// File: rtl/red_pitaya_pwm_dither.sv
// Dithered PWM generator: 8-bit duty over a 256-clock period, stretched by one
// clock in the periods selected by a 16-bit pattern, giving 12-bit resolution
// across a 16-period dither cycle. Configuration is shadowed at the period
// boundary so a change never produces a partial or glitched period.
module red_pitaya_pwm_dither
  import pwm_pkg::*;
(
  input  logic           clk_i,
  input  logic           rstn_i,
  input  logic [CCW-1:0] cfg_i,
  output logic           pwm_o,
  output logic           period_o,
  output logic           seq_o
);

  localparam logic [7:0] CNT_LAST = 8'(PERIOD - 1);
  localparam logic [3:0] IDX_LAST = 4'(NSEQ - 1);

  logic [7:0]       cnt_reg;
  logic [3:0]       idx_reg;
  logic [7:0]       duty_reg;
  logic [PAT_MSB:0] pat_reg;

  logic             boundary;
  logic             dither_bit;
  logic [8:0]       high_len;
  logic             pwm_next;

  // Boundary detect, current dither bit and the 9-bit compare; the extra bit
  // lets duty 255 plus dither reach a full 256-clock high period.
  always_comb begin
    boundary   = (cnt_reg == CNT_LAST);
    dither_bit = pat_reg[idx_reg];
    high_len   = {1'b0, duty_reg} + {8'd0, dither_bit};
    pwm_next   = ({1'b0, cnt_reg} < high_len);
  end

  // Period counter, dither index, shadow registers and registered outputs
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_reg  <= 8'd0;
      idx_reg  <= 4'd0;
      duty_reg <= 8'd0;
      pat_reg  <= '0;
      pwm_o    <= 1'b0;
      period_o <= 1'b0;
      seq_o    <= 1'b0;
    end else begin
      cnt_reg  <= cnt_reg + 8'd1;
      pwm_o    <= pwm_next;
      period_o <= boundary;
      seq_o    <= boundary && (idx_reg == IDX_LAST);
      if (boundary) begin
        idx_reg  <= idx_reg + 4'd1;
        duty_reg <= cfg_i[DUTY_MSB:DUTY_LSB];
        pat_reg  <= cfg_i[PAT_MSB:0];
      end
    end
  end

endmodule : red_pitaya_pwm_dither
